// File: rtl/nn_config_sequencer.sv
// Walks a flat weight-then-bias config stream into per-layer/neuron write strobes.
// Latency 1 cycle word-to-strobe; cfg_in_ready is high only in WEIGHT/BIAS, so the source stalls otherwise.
module nn_config_sequencer #(
  parameter int                       DATA_WIDTH    = 16,
  parameter int                       NUM_LAYERS    = 4,
  parameter logic [8*NUM_LAYERS-1:0]  LAYER_NEURONS = {8'd10, 8'd10, 8'd30, 8'd30},
  parameter logic [16*NUM_LAYERS-1:0] LAYER_WEIGHTS = {16'd10, 16'd30, 16'd30, 16'd784}
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] cfg_in_data,
  input  logic                  cfg_in_valid,
  output logic                  cfg_in_ready,
  output logic [7:0]            cfg_layer,
  output logic [7:0]            cfg_neuron,
  output logic [DATA_WIDTH-1:0] cfg_data,
  output logic                  cfg_wr_weight,
  output logic                  cfg_wr_bias,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {S_IDLE, S_WEIGHT, S_BIAS, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_layer, r_neuron, w_layer_nxt, w_neuron_nxt;
  logic [15:0]           r_weight, w_weight_nxt;
  logic [15:0]           w_layer_weights;
  logic [7:0]            w_layer_neurons;
  logic                  w_accept, w_last_weight, w_last_neuron, w_last_layer;
  logic                  w_wr_weight, w_wr_bias;
  logic                  r_ready, r_busy, r_done, r_wr_weight, r_wr_bias;
  logic [7:0]            r_out_layer, r_out_neuron;
  logic [DATA_WIDTH-1:0] r_data;

  // Per-layer limits selected by the current layer index (1-based).
  always_comb begin
    w_layer_weights = 16'd0;
    w_layer_neurons = 8'd0;
    for (int k = 1; k <= NUM_LAYERS; k++) begin
      if (r_layer == 8'(k)) begin
        w_layer_weights = LAYER_WEIGHTS[16*k-1 -: 16];
        w_layer_neurons = LAYER_NEURONS[8*k-1 -: 8];
      end
    end
  end

  assign w_accept      = cfg_in_valid && r_ready;
  assign w_last_weight = (r_weight == w_layer_weights - 16'd1);
  assign w_last_neuron = (r_neuron == w_layer_neurons - 8'd1);
  assign w_last_layer  = (r_layer == 8'(NUM_LAYERS));

  always_comb begin
    w_state_nxt  = r_state;
    w_layer_nxt  = r_layer;
    w_neuron_nxt = r_neuron;
    w_weight_nxt = r_weight;
    w_wr_weight  = 1'b0;
    w_wr_bias    = 1'b0;
    if (abort) begin
      w_state_nxt  = S_IDLE;
      w_layer_nxt  = 8'd1;
      w_neuron_nxt = 8'd0;
      w_weight_nxt = 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_state_nxt  = S_WEIGHT;
            w_layer_nxt  = 8'd1;
            w_neuron_nxt = 8'd0;
            w_weight_nxt = 16'd0;
          end
        end
        S_WEIGHT: begin
          if (w_accept) begin
            w_wr_weight = 1'b1;
            if (!w_last_weight) begin
              w_weight_nxt = r_weight + 16'd1;
            end else begin
              w_weight_nxt = 16'd0;
              if (!w_last_neuron) begin
                w_neuron_nxt = r_neuron + 8'd1;
              end else begin
                w_neuron_nxt = 8'd0;
                if (w_last_layer) begin
                  w_layer_nxt = 8'd1;
                  w_state_nxt = S_BIAS;
                end else begin
                  w_layer_nxt = r_layer + 8'd1;
                end
              end
            end
          end
        end
        S_BIAS: begin
          if (w_accept) begin
            w_wr_bias = 1'b1;
            if (!w_last_neuron) begin
              w_neuron_nxt = r_neuron + 8'd1;
            end else begin
              w_neuron_nxt = 8'd0;
              if (w_last_layer) begin
                w_layer_nxt = 8'd1;
                w_state_nxt = S_DONE;
              end else begin
                w_layer_nxt = r_layer + 8'd1;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Status flags are registered from the next state so they line up with it.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      r_state      <= S_IDLE;
      r_layer      <= 8'd1;
      r_neuron     <= 8'd0;
      r_weight     <= 16'd0;
      r_ready      <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_wr_weight  <= 1'b0;
      r_wr_bias    <= 1'b0;
      r_out_layer  <= 8'd1;
      r_out_neuron <= 8'd0;
      r_data       <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_layer     <= w_layer_nxt;
      r_neuron    <= w_neuron_nxt;
      r_weight    <= w_weight_nxt;
      r_ready     <= (w_state_nxt == S_WEIGHT) || (w_state_nxt == S_BIAS);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_DONE);
      r_wr_weight <= w_wr_weight;
      r_wr_bias   <= w_wr_bias;
      // Selects move only with a strobe so they hold steady between writes.
      if (w_wr_weight || w_wr_bias) begin
        r_out_layer  <= r_layer;
        r_out_neuron <= r_neuron;
        r_data       <= cfg_in_data;
      end
    end
  end

  assign cfg_in_ready  = r_ready;
  assign cfg_layer     = r_out_layer;
  assign cfg_neuron    = r_out_neuron;
  assign cfg_data      = r_data;
  assign cfg_wr_weight = r_wr_weight;
  assign cfg_wr_bias   = r_wr_bias;
  assign busy          = r_busy;
  assign done          = r_done;

endmodule

// File: tb/tb_nn_config_sequencer.sv
// Scoreboard bench for nn_config_sequencer with a 2-layer (2x4, 3x2) configuration.
module tb_nn_config_sequencer;

  localparam int TOTAL = 19;

  logic        s_axi_aclk = 1'b0;
  logic        s_axi_aresetn;
  logic        start, abort, cfg_in_valid;
  logic [15:0] cfg_in_data;
  logic        cfg_in_ready, cfg_wr_weight, cfg_wr_bias, busy, done;
  logic [7:0]  cfg_layer, cfg_neuron;
  logic [15:0] cfg_data;

  nn_config_sequencer #(
    .DATA_WIDTH(16),
    .NUM_LAYERS(2),
    .LAYER_NEURONS({8'd3, 8'd2}),
    .LAYER_WEIGHTS({16'd2, 16'd4})
  ) dut (
    .s_axi_aclk(s_axi_aclk), .s_axi_aresetn(s_axi_aresetn),
    .start(start), .abort(abort),
    .cfg_in_data(cfg_in_data), .cfg_in_valid(cfg_in_valid), .cfg_in_ready(cfg_in_ready),
    .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron), .cfg_data(cfg_data),
    .cfg_wr_weight(cfg_wr_weight), .cfg_wr_bias(cfg_wr_bias),
    .busy(busy), .done(done)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  typedef struct {
    int bias;
    int layer;
    int neuron;
    int data;
  } exp_t;

  exp_t tbl[TOTAL];
  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   t_start = 0;
  int   t_done = 0;

  task automatic chk(input string tag, input longint got, input longint want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  always @(posedge s_axi_aclk) cyc++;

  always @(negedge s_axi_aclk) begin
    if (s_axi_aresetn) begin
      if (cfg_wr_weight && cfg_wr_bias) chk("both_strobes", 1, 0);
      if (cfg_wr_weight || cfg_wr_bias) begin
        if (exp_q.size() == 0) begin
          chk("spurious_strobe", cfg_data, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("strobe_kind", cfg_wr_bias, e.bias);
          chk("layer", cfg_layer, e.layer);
          chk("neuron", cfg_neuron, e.neuron);
          chk("data", cfg_data, e.data);
        end
      end
      if (done) begin
        done_cnt++;
        t_done = cyc;
        chk("done_with_last_bias", cfg_wr_bias, 1);
      end
    end
  end

  task automatic do_start();
    start = 1'b1;
    t_start = cyc;
    @(negedge s_axi_aclk);
    start = 1'b0;
  endtask

  task automatic send(input int i);
    int n;
    n = 0;
    cfg_in_valid = 1'b1;
    cfg_in_data  = 16'(tbl[i].data);
    while (!cfg_in_ready && n < 20) begin
      @(negedge s_axi_aclk);
      n++;
    end
    if (!cfg_in_ready) chk("ready_timeout", 0, 1);
    else exp_q.push_back(tbl[i]);
    @(negedge s_axi_aclk);
    cfg_in_valid = 1'b0;
  endtask

  task automatic run_load(input bit gaps, input bit st_mid, input bit st_done);
    int dc0;
    dc0 = done_cnt;
    do_start();
    for (int i = 0; i < TOTAL; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) @(negedge s_axi_aclk);
      if (st_mid && i == 4) start = 1'b1;
      send(i);
      start = 1'b0;
    end
    if (st_done) start = 1'b1;
    @(negedge s_axi_aclk);
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("ready_after_done", cfg_in_ready, 0);
    if (!gaps) chk("done_latency", t_done - t_start, 20);
    repeat (3) @(negedge s_axi_aclk);
    chk("done_count", done_cnt - dc0, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_after_load", busy, 0);
  endtask

  initial begin
    int idx, dc0;
    int nn[2];
    int ww[2];
    nn = '{2, 3};
    ww = '{4, 2};
    idx = 0;
    for (int l = 0; l < 2; l++)
      for (int n = 0; n < nn[l]; n++)
        for (int w = 0; w < ww[l]; w++) begin
          tbl[idx] = '{0, l + 1, n, idx + 1};
          idx++;
        end
    for (int l = 0; l < 2; l++)
      for (int n = 0; n < nn[l]; n++) begin
        tbl[idx] = '{1, l + 1, n, idx + 1};
        idx++;
      end

    s_axi_aresetn = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    cfg_in_valid = 1'b0;
    cfg_in_data = 16'd0;
    repeat (3) @(negedge s_axi_aclk);
    chk("rst_ready", cfg_in_ready, 0);
    chk("rst_layer", cfg_layer, 1);
    chk("rst_neuron", cfg_neuron, 0);
    chk("rst_data", cfg_data, 0);
    chk("rst_wr_weight", cfg_wr_weight, 0);
    chk("rst_wr_bias", cfg_wr_bias, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    s_axi_aresetn = 1'b1;
    repeat (2) @(negedge s_axi_aclk);
    chk("idle_ready", cfg_in_ready, 0);

    run_load(1'b0, 1'b0, 1'b0);
    run_load(1'b1, 1'b0, 1'b0);

    dc0 = done_cnt;
    do_start();
    for (int i = 0; i < 6; i++) send(i);
    cfg_in_valid = 1'b1;
    cfg_in_data  = 16'd7;
    abort = 1'b1;
    @(negedge s_axi_aclk);
    abort = 1'b0;
    cfg_in_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ready", cfg_in_ready, 0);
    chk("abort_no_strobe", cfg_wr_weight, 0);
    repeat (2) @(negedge s_axi_aclk);
    chk("abort_no_done", done_cnt - dc0, 0);
    run_load(1'b0, 1'b0, 1'b0);

    run_load(1'b0, 1'b1, 1'b1);

    dc0 = done_cnt;
    do_start();
    for (int i = 0; i < 16; i++) send(i);
    #2 s_axi_aresetn = 1'b0;
    #1;
    chk("arst_ready", cfg_in_ready, 0);
    chk("arst_layer", cfg_layer, 1);
    chk("arst_neuron", cfg_neuron, 0);
    chk("arst_data", cfg_data, 0);
    chk("arst_strobes", {cfg_wr_weight, cfg_wr_bias}, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_queue", exp_q.size(), 0);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    cfg_in_valid = 1'b1;
    repeat (4) @(negedge s_axi_aclk);
    chk("post_rst_ready", cfg_in_ready, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_no_done", done_cnt - dc0, 0);
    cfg_in_valid = 1'b0;
    run_load(1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
